bin_histogram: RTL and testbench
================================

# bin_histogram

Downstream consumer of the 3-bit range-bin code produced by the data classifier. The block counts how often each bin code occurs over a fixed window of valid samples. At the end of each window it presents the per-bin totals on a valid/ready output port. Upstream has no backpressure, so accumulation never stalls; if a result is not taken in time, it is overwritten and the loss is flagged.

## Interface
- WIN_LEN, 16: number of valid samples per window; legal range 2..255.
- CNT_W, 5: width of each count field; must satisfy 2^CNT_W > WIN_LEN.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous window restart; clears accumulators and the sample counter only.
- in_valid  input  1  in_bin carries a sample this cycle.
- in_bin  input  3  bin code; legal values 1..4; 0 and 5..7 are illegal.
- out_valid  output  1  a window result is held on the out_* fields.
- out_ready  input  1  consumer accepts the result.
- out_cnt1..out_cnt4  output  CNT_W each  occurrences of codes 1..4 in the window.
- out_err  output  CNT_W  occurrences of illegal codes in the window.
- out_lost  output  1  sticky: at least one completed window overwrote an untaken result.

## Operation
- Accumulators: acc1..acc4 and acc_err, each CNT_W bits, plus a sample counter smp of 8 bits.
- On each cycle with in_valid=1 and clr=0:
  - increment the accumulator selected by in_bin; codes 0 and 5..7 increment acc_err;
  - increment smp.
- Illegal codes count toward WIN_LEN. Invariant: the five output counts sum to WIN_LEN.
- Window completion happens on the sample where smp==WIN_LEN-1 and in_valid=1.
  - Output registers load the accumulator values including that sample.
  - All accumulators and smp clear to 0 on the same edge.
  - The next valid sample is the first sample of the new window.
- Output state machine:
  - EMPTY: out_valid=0. Window completion loads the result and moves to FULL.
  - FULL: out_valid=1. If out_ready=1 and there is no completion, go to EMPTY.
  - FULL: if out_ready=1 and a completion occurs in the same cycle, load the new result and stay in FULL. No loss is flagged.
  - FULL: if out_ready=0 and a completion occurs, overwrite the outputs, set out_lost, and stay in FULL.
- Output fields are stable while out_valid=1 and out_ready=0, except when overwritten as above.
- clr:
  - clears acc* and smp; the in_valid sample in that cycle is discarded;
  - has no effect on out_valid, out_cnt*, out_err, or out_lost.
- Priority: rst > clr > sample accumulation.
- No counter wraps, because 2^CNT_W > WIN_LEN.

## Timing
- Reset values: out_valid=0, out_cnt1..4=0, out_err=0, out_lost=0; acc*=0, smp=0; state EMPTY.
- Reset mid-window discards the partial window. Reset while FULL drops the pending result.
- Latency: out_valid rises on the first rising edge after the completing sample is sampled, i.e. 1 cycle.
- Throughput: one sample per cycle, sustained indefinitely.
- With continuous input, results arrive every WIN_LEN cycles.
- A transfer occurs on any rising edge with out_valid=1 and out_ready=1.
- out_valid falls on the edge following a transfer, unless a new result loads on that same edge.
- out_lost rises on the edge of the overwriting load and stays high until rst.
- out_valid does not depend combinationally on out_ready; all outputs are registered.

## Test plan
- Reset, then apply WIN_LEN=4 with in_bin 1,2,3,4 on consecutive valid cycles and out_ready=1 -> one cycle after the 4th sample: out_valid=1, cnt1..4=1,1,1,1, err=0; out_valid=0 the following cycle.
- WIN_LEN=4 with in_bin 0,7,4,4 and gaps of in_valid=0 between samples -> result cnt4=2, err=2, others 0; gap cycles do not advance smp.
- WIN_LEN=4, continuous stream of code 2, out_ready=0 -> first result cnt2=4, out_valid=1, held stable 4 cycles; second completion overwrites it, out_lost=1 and stays 1 until rst.
- WIN_LEN=4, continuous stream, out_ready pulsed high exactly on each completion-load cycle -> out_valid stays 1 continuously, a new result every 4 cycles, out_lost=0.
- Assert clr after 2 samples of code 3, then send 4 samples of code 1 -> result cnt1=4, cnt3=0; a clr coinciding with in_valid drops that sample.
- Assert rst asynchronously mid-window and while FULL -> all outputs 0 immediately; after release, a full fresh window of code 4 is required before out_valid=1 with cnt4=WIN_LEN.

Source files
------------

// File: rtl/bin_histogram.sv
// Window histogram of 3-bit range-bin codes: counts codes 1..4 and illegal codes over
// WIN_LEN valid samples, then offers the totals on a valid/ready port that never stalls input.
module bin_histogram #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [2:0]       in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt1,
    output logic [CNT_W-1:0] out_cnt2,
    output logic [CNT_W-1:0] out_cnt3,
    output logic [CNT_W-1:0] out_cnt4,
    output logic [CNT_W-1:0] out_err,
    output logic             out_lost
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] acc1, acc2, acc3, acc4, acc_err;
    logic [CNT_W-1:0] nxt1, nxt2, nxt3, nxt4, nxt_err;
    logic [7:0]       smp;
    logic             sample, complete;
    logic             hit1, hit2, hit3, hit4, hit_err;

    // Sums that include the current sample, so a completing sample lands in the result.
    always_comb begin
        sample   = in_valid && !clr;
        complete = sample && (smp == 8'(WIN_LEN - 1));
        hit1     = sample && (in_bin == 3'd1);
        hit2     = sample && (in_bin == 3'd2);
        hit3     = sample && (in_bin == 3'd3);
        hit4     = sample && (in_bin == 3'd4);
        hit_err  = sample && ((in_bin == 3'd0) || (in_bin > 3'd4));
        nxt1     = acc1 + {{(CNT_W-1){1'b0}}, hit1};
        nxt2     = acc2 + {{(CNT_W-1){1'b0}}, hit2};
        nxt3     = acc3 + {{(CNT_W-1){1'b0}}, hit3};
        nxt4     = acc4 + {{(CNT_W-1){1'b0}}, hit4};
        nxt_err  = acc_err + {{(CNT_W-1){1'b0}}, hit_err};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc1    <= '0;
            acc2    <= '0;
            acc3    <= '0;
            acc4    <= '0;
            acc_err <= '0;
            smp     <= '0;
        end else if (clr || complete) begin
            acc1    <= '0;
            acc2    <= '0;
            acc3    <= '0;
            acc4    <= '0;
            acc_err <= '0;
            smp     <= '0;
        end else if (sample) begin
            acc1    <= nxt1;
            acc2    <= nxt2;
            acc3    <= nxt3;
            acc4    <= nxt4;
            acc_err <= nxt_err;
            smp     <= smp + 8'd1;
        end
    end

    // Result registers only change on a completion; clr deliberately leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt1 <= '0;
            out_cnt2 <= '0;
            out_cnt3 <= '0;
            out_cnt4 <= '0;
            out_err  <= '0;
            out_lost <= 1'b0;
        end else if (complete) begin
            out_cnt1 <= nxt1;
            out_cnt2 <= nxt2;
            out_cnt3 <= nxt3;
            out_cnt4 <= nxt4;
            out_err  <= nxt_err;
            if (state == FULL && !out_ready)
                out_lost <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (complete) state_next = FULL;
            FULL: begin
                if (complete)
                    state_next = FULL;
                else if (out_ready)
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_bin_histogram.sv
// Self-checking bench for bin_histogram: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a window-level behavioural model.
module tb_bin_histogram;

    localparam int WIN_LEN = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [2:0]       in_bin = 3'd0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_cnt1, out_cnt2, out_cnt3, out_cnt4, out_err;
    logic             out_lost;

    int checks = 0;
    int errors = 0;

    int m_acc[5];
    int m_out[5];
    int m_smp;
    bit m_valid;
    bit m_lost;

    bin_histogram #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cnt1(out_cnt1), .out_cnt2(out_cnt2), .out_cnt3(out_cnt3), .out_cnt4(out_cnt4),
        .out_err(out_err), .out_lost(out_lost)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit v, input bit [2:0] b, input bit rdy, input bit c);
        @(negedge clk);
        in_valid  = v;
        in_bin    = b;
        out_ready = rdy;
        clr       = c;
    endtask

    // Model: index 0 holds illegal codes, 1..4 the legal bins; a window closes after WIN_LEN samples.
    always @(posedge clk or posedge rst) begin
        int a[5];
        int o[5];
        int s, idx;
        bit v, l, done;
        if (rst) begin
            m_acc   <= '{default: 0};
            m_out   <= '{default: 0};
            m_smp   <= 0;
            m_valid <= 1'b0;
            m_lost  <= 1'b0;
        end else begin
            a = m_acc; o = m_out; s = m_smp; v = m_valid; l = m_lost; done = 1'b0;
            if (clr) begin
                a = '{default: 0};
                s = 0;
            end else if (in_valid) begin
                idx = (in_bin >= 3'd1 && in_bin <= 3'd4) ? int'(in_bin) : 0;
                a[idx] = a[idx] + 1;
                s = s + 1;
                if (s == WIN_LEN) begin
                    done = 1'b1;
                    if (v && !out_ready) l = 1'b1;
                    o = a;
                    v = 1'b1;
                    a = '{default: 0};
                    s = 0;
                end
            end
            if (!done && v && out_ready) v = 1'b0;
            m_acc   <= a;
            m_out   <= o;
            m_smp   <= s;
            m_valid <= v;
            m_lost  <= l;
        end
    end

    always @(negedge clk) begin
        check_output("model out_valid", int'(out_valid), int'(m_valid));
        check_output("model out_lost",  int'(out_lost),  int'(m_lost));
        check_output("model out_cnt1",  int'(out_cnt1),  m_out[1]);
        check_output("model out_cnt2",  int'(out_cnt2),  m_out[2]);
        check_output("model out_cnt3",  int'(out_cnt3),  m_out[3]);
        check_output("model out_cnt4",  int'(out_cnt4),  m_out[4]);
        check_output("model out_err",   int'(out_err),   m_out[0]);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_output("reset out_valid", int'(out_valid), 0);
        check_output("reset out_lost", int'(out_lost), 0);
        check_output("reset out_cnt1", int'(out_cnt1), 0);
        rst = 1'b0;

        // One of each legal code, consumer always ready.
        apply_stimulus(1, 3'd1, 1, 0);
        apply_stimulus(1, 3'd2, 1, 0);
        apply_stimulus(1, 3'd3, 1, 0);
        apply_stimulus(1, 3'd4, 1, 0);
        apply_stimulus(0, 3'd0, 1, 0);
        check_output("t1 out_valid", int'(out_valid), 1);
        check_output("t1 cnt1", int'(out_cnt1), 1);
        check_output("t1 cnt2", int'(out_cnt2), 1);
        check_output("t1 cnt3", int'(out_cnt3), 1);
        check_output("t1 cnt4", int'(out_cnt4), 1);
        check_output("t1 err", int'(out_err), 0);
        apply_stimulus(0, 3'd0, 1, 0);
        check_output("t1 out_valid drop", int'(out_valid), 0);

        // Illegal codes with idle gaps in between.
        apply_stimulus(1, 3'd0, 1, 0);
        apply_stimulus(0, 3'd1, 1, 0);
        apply_stimulus(1, 3'd7, 1, 0);
        apply_stimulus(0, 3'd1, 1, 0);
        apply_stimulus(1, 3'd4, 1, 0);
        apply_stimulus(0, 3'd1, 1, 0);
        check_output("t2 no early valid", int'(out_valid), 0);
        apply_stimulus(1, 3'd4, 1, 0);
        apply_stimulus(0, 3'd0, 1, 0);
        check_output("t2 out_valid", int'(out_valid), 1);
        check_output("t2 cnt4", int'(out_cnt4), 2);
        check_output("t2 err", int'(out_err), 2);
        check_output("t2 cnt1", int'(out_cnt1), 0);

        // Consumer stalled: second completion overwrites and flags the loss.
        for (int i = 0; i < 4; i++) apply_stimulus(1, 3'd2, 0, 0);
        apply_stimulus(1, 3'd2, 0, 0);
        check_output("t3 first valid", int'(out_valid), 1);
        check_output("t3 first cnt2", int'(out_cnt2), 4);
        check_output("t3 no loss yet", int'(out_lost), 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 3'd2, 0, 0);
        apply_stimulus(0, 3'd0, 0, 0);
        check_output("t3 lost set", int'(out_lost), 1);
        check_output("t3 still valid", int'(out_valid), 1);
        apply_stimulus(0, 3'd0, 1, 0);
        apply_stimulus(0, 3'd0, 1, 0);
        check_output("t3 lost sticky", int'(out_lost), 1);
        check_output("t3 taken", int'(out_valid), 0);
        #2 rst = 1'b1;
        #1 check_output("t3 rst clears lost", int'(out_lost), 0);
        @(negedge clk) rst = 1'b0;

        // Ready only on completion cycles keeps a result continuously on offer.
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 4; s++) begin
                apply_stimulus(1, 3'(w + 1), (w > 0 && s == 3), 0);
                if (w > 0) check_output("t4 valid held", int'(out_valid), 1);
            end
        end
        apply_stimulus(0, 3'd0, 0, 0);
        check_output("t4 last cnt4", int'(out_cnt4), 4);
        check_output("t4 no loss", int'(out_lost), 0);

        // clr after two samples, plus a clr that swallows a coincident sample.
        apply_stimulus(1, 3'd3, 1, 0);
        apply_stimulus(1, 3'd3, 1, 0);
        apply_stimulus(1, 3'd3, 1, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 3'd1, 1, 0);
        apply_stimulus(0, 3'd0, 1, 0);
        check_output("t5 cnt1", int'(out_cnt1), 4);
        check_output("t5 cnt3", int'(out_cnt3), 0);

        // Async reset mid-window needs a complete fresh window afterwards.
        apply_stimulus(1, 3'd4, 1, 0);
        apply_stimulus(1, 3'd4, 1, 0);
        #2 rst = 1'b1;
        #1 check_output("t6 rst valid", int'(out_valid), 0);
        check_output("t6 rst cnt1", int'(out_cnt1), 0);
        @(negedge clk) rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(1, 3'd4, 0, 0);
        apply_stimulus(0, 3'd0, 0, 0);
        check_output("t6 not yet valid", int'(out_valid), 0);
        apply_stimulus(1, 3'd4, 0, 0);
        apply_stimulus(0, 3'd0, 0, 0);
        check_output("t6 valid", int'(out_valid), 1);
        check_output("t6 cnt4", int'(out_cnt4), WIN_LEN);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(99) < 75, 3'($urandom_range(7)),
                           $urandom_range(99) < 50, $urandom_range(99) < 3);
        end
        apply_stimulus(0, 3'd0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
